// File: rtl/interrupt_request_controller_pkg.sv
// Shared types and constants for the 6-line interrupt request controller.
// The FSM encoding and vector width are fixed to match the 6-to-3 encoder.
package interrupt_request_controller_pkg;

  localparam int N_IRQ = 6;
  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] NO_VECTOR = 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Encoder code 1..N_IRQ maps to a one-hot line; 0 and 7 select no line.
  function automatic logic [N_IRQ-1:0] vec_to_onehot(input logic [VEC_W-1:0] v);
    logic [N_IRQ-1:0] r;
    r = '0;
    if ((v != NO_VECTOR) && (v <= VEC_W'(N_IRQ)))
      r = N_IRQ'(1) << (v - 3'd1);
    return r;
  endfunction

endpackage

// File: rtl/interrupt_request_controller_if.sv
// Bus bundle between the interrupt controller, its IRQ sources, the encoder and the CPU.
// The slave modport is the controller's view; master is the environment's view.
interface interrupt_request_controller_if;
  import interrupt_request_controller_pkg::*;

  logic [N_IRQ-1:0] IRQ_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_in;
  logic [N_IRQ-1:0] pend_out;
  logic [VEC_W-1:0] enc_in;
  logic             INTR;
  logic             INTA;
  logic             EOI;
  logic [VEC_W-1:0] vector_out;
  logic             in_service;

  modport slave (
    input  IRQ_in, mask_we, mask_in, enc_in, INTA, EOI,
    output pend_out, INTR, vector_out, in_service
  );

  modport master (
    output IRQ_in, mask_we, mask_in, enc_in, INTA, EOI,
    input  pend_out, INTR, vector_out, in_service
  );

endinterface

// File: rtl/interrupt_request_controller_sync.sv
// Multi-flop synchroniser for the raw IRQ lines followed by a rising-edge detector.
// One instance handles the whole IRQ vector; rise is a single-cycle pulse per edge.
module irq_sync_edge #(
  parameter int N           = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] async_in,
  output logic [N-1:0] rise
);

  logic [SYNC_STAGES-1:0][N-1:0] sync_reg;
  logic [N-1:0]                  prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/interrupt_request_controller.sv
// Interrupt front end: synchronise and edge-detect IRQs, hold/mask pending requests,
// and run the INTR/INTA/EOI handshake with single-level in-service tracking.
module interrupt_request_controller
  import interrupt_request_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  interrupt_request_controller_if.slave  bus
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg, mask_next;
  logic [N_IRQ-1:0] pend_out_reg;
  logic [N_IRQ-1:0] clear_vec;
  logic [VEC_W-1:0] vector_reg, vector_next;
  logic             in_service_reg, in_service_next;
  logic             accept;
  irq_state_e       state_reg, state_next;

  irq_sync_edge #(
    .N           (N_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.IRQ_in),
    .rise     (rise)
  );

  // enc_in is only trusted while pend_out is non-zero, so an INTA that
  // coincides with a fully withdrawn request is dropped rather than
  // delivering the encoder's stale code.
  always_comb begin
    state_next      = state_reg;
    vector_next     = vector_reg;
    in_service_next = in_service_reg;
    accept          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_out_reg != '0) state_next = REQ;
      end
      REQ: begin
        if (bus.INTA && (pend_out_reg != '0)) begin
          accept          = 1'b1;
          vector_next     = bus.enc_in;
          in_service_next = 1'b1;
          state_next      = SERVICE;
        end else if (pend_out_reg == '0) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (bus.EOI) begin
          vector_next     = NO_VECTOR;
          in_service_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A fresh edge on the acknowledged line survives the clear.
    clear_vec    = accept ? vec_to_onehot(bus.enc_in) : '0;
    pending_next = (pending_reg & ~clear_vec) | rise;
    mask_next    = bus.mask_we ? bus.mask_in : mask_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      mask_reg       <= '0;
      pend_out_reg   <= '0;
      vector_reg     <= NO_VECTOR;
      in_service_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      mask_reg       <= mask_next;
      pend_out_reg   <= pending_next & ~mask_next;
      vector_reg     <= vector_next;
      in_service_reg <= in_service_next;
    end
  end

  assign bus.pend_out   = pend_out_reg;
  assign bus.INTR       = (state_reg == REQ);
  assign bus.vector_out = vector_reg;
  assign bus.in_service = in_service_reg;

endmodule
